shift_add_mult: RTL and testbench

SHIFT_ADD_MULT -- requirements
Module: shift_add_mult

---
 rtl/mult_pkg.sv | 10 +
 rtl/rca.sv | 27 ++
 rtl/shift_add_mult.sv | 103 ++++++++++
 tb/tb_shift_add_mult.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier: FSM state encoding.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/rca.sv
// Ripple-carry adder: Bits-wide sum plus carry-out, one full adder per bit.
module rca #(
    parameter int Bits = 8
) (
    input  logic [Bits-1:0] a,
    input  logic [Bits-1:0] b,
    input  logic            cin,
    output logic [Bits-1:0] sum,
    output logic            cout
);

    logic [Bits:0] carry;

    assign carry[0] = cin;

    // One full adder per bit position, carry rippling upward.
    genvar gi;
    generate
        for (gi = 0; gi < Bits; gi++) begin : g_fa
            assign sum[gi]       = a[gi] ^ b[gi] ^ carry[gi];
            assign carry[gi + 1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout = carry[Bits];

endmodule

// File: rtl/shift_add_mult.sv
// Sequential unsigned multiplier: one shift-add step per clock,
// Bits steps per operation, product registered on entry to DONE.
module shift_add_mult
    import mult_pkg::*;
#(
    parameter int Bits = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [Bits-1:0]   a,
    input  logic [Bits-1:0]   b,
    output logic              busy,
    output logic              done,
    output logic [2*Bits-1:0] product
);

    localparam int CW = $clog2(Bits + 1);

    state_t            state_reg;
    logic [Bits-1:0]   mcand_reg;
    logic [Bits-1:0]   mplier_reg;
    logic [Bits-1:0]   acc_hi_reg;
    logic [CW-1:0]     count_reg;
    logic [2*Bits-1:0] product_reg;

    logic [Bits-1:0]   add_sum;
    logic              add_cout;
    logic [Bits:0]     step_sum;
    logic [Bits-1:0]   acc_hi_next;
    logic [Bits-1:0]   mplier_next;

    // The only adder on the datapath; its carry-out becomes the bit shifted
    // into the top of the accumulator.
    rca #(
        .Bits (Bits)
    ) u_rca (
        .a    (acc_hi_reg),
        .b    (mcand_reg),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Select partial sum {c,s}: add the multiplicand only when the current
    // multiplier LSB is set.
    always_comb begin
        step_sum = {1'b0, acc_hi_reg};
        if (mplier_reg[0]) begin
            step_sum = {add_cout, add_sum};
        end
    end

    // {acc_hi, mplier} <= {c, s, mplier} >> 1
    assign acc_hi_next = step_sum[Bits:1];
    assign mplier_next = {step_sum[0], mplier_reg[Bits-1:1]};

    // FSM plus datapath registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            mcand_reg   <= '0;
            mplier_reg  <= '0;
            acc_hi_reg  <= '0;
            count_reg   <= '0;
            product_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        mcand_reg  <= a;
                        mplier_reg <= b;
                        acc_hi_reg <= '0;
                        count_reg  <= CW'(Bits);
                        state_reg  <= CALC;
                    end
                end
                CALC: begin
                    acc_hi_reg <= acc_hi_next;
                    mplier_reg <= mplier_next;
                    count_reg  <= count_reg - CW'(1);
                    // Last step: capture the finished product directly from
                    // the shifter so it is valid during the DONE cycle.
                    if (count_reg == CW'(1)) begin
                        product_reg <= {acc_hi_next, mplier_next};
                        state_reg   <= DONE;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy    = (state_reg != IDLE);
    assign done    = (state_reg == DONE);
    assign product = product_reg;

endmodule

// File: tb/tb_shift_add_mult.sv
// Directed testbench for shift_add_mult (Bits=8 and Bits=4 instances).
module tb_shift_add_mult;
    import mult_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start8;
    logic [7:0]  a8, b8;
    logic        busy8, done8;
    logic [15:0] product8;
    logic        start4;
    logic [3:0]  a4, b4;
    logic        busy4, done4;
    logic [7:0]  product4;

    int checks = 0;
    int errors = 0;

    shift_add_mult #(.Bits(8)) dut8 (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start8),
        .a       (a8),
        .b       (b8),
        .busy    (busy8),
        .done    (done8),
        .product (product8)
    );

    shift_add_mult #(.Bits(4)) dut4 (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start4),
        .a       (a4),
        .b       (b4),
        .busy    (busy4),
        .done    (done4),
        .product (product4)
    );

    // Stimulus: present a start for one edge; returns just after the capture edge.
    task automatic issue8(input logic [7:0] av, input logic [7:0] bv);
        start8 = 1'b1;
        a8     = av;
        b8     = bv;
        @(posedge clk); #1;
        start8 = 1'b0;
    endtask

    // Monitor: latency counts the capture edge as 1; busy_cycles counts sampled busy cycles.
    task automatic wait_done8(output int lat, output int busy_cycles, output bit seen);
        lat = 1;
        busy_cycles = 0;
        seen = 1'b0;
        if (busy8) busy_cycles++;
        for (int k = 0; k < 40; k++) begin
            if (done8) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
            lat++;
            if (busy8) busy_cycles++;
        end
    endtask

    task automatic count_done8(input int n, output int pulses);
        pulses = 0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            if (done8) pulses++;
        end
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        start8 = 1'b1;
        a8     = 8'h55;
        b8     = 8'h33;
        start4 = 1'b1;
        a4     = 4'h3;
        b4     = 4'h5;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy8); end
        checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done8); end
        checks++; if (product8 !== 16'h0000) begin errors++; $display("FAIL reset_product: got %h expected 0000", product8); end
        checks++; if (dut8.state_reg !== IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", dut8.state_reg, IDLE); end
        checks++; if (busy4 !== 1'b0 || product4 !== 8'h00) begin errors++; $display("FAIL reset_dut4: got busy=%b product=%h expected busy=0 product=00", busy4, product4); end
        start8 = 1'b0;
        start4 = 1'b0;
        rst_n  = 1'b1;
        @(posedge clk); #1;
        checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_release_idle: got busy=%b expected 0", busy8); end
        $display("test_reset done");
    endtask

    task automatic test_max();
        int lat, bc;
        bit seen;
        issue8(8'hFF, 8'hFF);
        a8 = 8'h00;
        b8 = 8'h00;
        checks++; if (busy8 !== 1'b1) begin errors++; $display("FAIL max_busy_start: got %b expected 1", busy8); end
        wait_done8(lat, bc, seen);
        checks++; if (!seen) begin errors++; $display("FAIL max_timeout: got no done expected done"); end
        checks++; if (lat != 9) begin errors++; $display("FAIL max_latency: got %0d expected 9", lat); end
        checks++; if (product8 !== 16'hFE01) begin errors++; $display("FAIL max_product: got %h expected fe01", product8); end
        checks++; if (bc != 9) begin errors++; $display("FAIL max_busy_cycles: got %0d expected 9", bc); end
        @(posedge clk); #1;
        checks++; if (busy8 !== 1'b0 || done8 !== 1'b0) begin errors++; $display("FAIL max_after_done: got busy=%b done=%b expected 0 0", busy8, done8); end
        checks++; if (product8 !== 16'hFE01) begin errors++; $display("FAIL max_product_hold: got %h expected fe01", product8); end
        $display("test_max: 0xff*0xff product=%h latency=%0d busy=%0d", product8, lat, bc);
    endtask

    task automatic test_zero_one();
        int lat, bc;
        bit seen;
        issue8(8'h00, 8'hA5);
        wait_done8(lat, bc, seen);
        checks++; if (!seen || product8 !== 16'h0000) begin errors++; $display("FAIL zero_product: got %h seen=%b expected 0000", product8, seen); end
        @(posedge clk); #1;
        $display("test_zero_one: 0x00*0xa5 product=%h", product8);
        issue8(8'hAB, 8'h01);
        wait_done8(lat, bc, seen);
        checks++; if (!seen || product8 !== 16'h00AB) begin errors++; $display("FAIL one_product: got %h seen=%b expected 00ab", product8, seen); end
        @(posedge clk); #1;
        $display("test_zero_one: 0xab*0x01 product=%h", product8);
    endtask

    task automatic test_start_ignored();
        int pulses;
        issue8(8'd12, 8'd13);
        checks++; if (product8 !== 16'h00AB) begin errors++; $display("FAIL ignored_hold_calc: got %h expected 00ab", product8); end
        start8 = 1'b1;
        a8     = 8'd3;
        b8     = 8'd3;
        repeat (3) begin
            @(posedge clk); #1;
        end
        start8 = 1'b0;
        count_done8(20, pulses);
        checks++; if (pulses != 1) begin errors++; $display("FAIL ignored_pulses: got %0d expected 1", pulses); end
        checks++; if (product8 !== 16'h009C) begin errors++; $display("FAIL ignored_product: got %h expected 009c", product8); end
        $display("test_start_ignored: 12*13 product=%h pulses=%0d", product8, pulses);
    endtask

    task automatic test_reset_abort();
        int pulses, lat, bc;
        bit seen;
        issue8(8'h7F, 8'h7F);
        repeat (3) begin
            @(posedge clk); #1;
        end
        checks++; if (busy8 !== 1'b1) begin errors++; $display("FAIL abort_in_calc: got busy=%b expected 1", busy8); end
        rst_n = 1'b0;
        #1;
        checks++; if (busy8 !== 1'b0 || done8 !== 1'b0) begin errors++; $display("FAIL abort_flags: got busy=%b done=%b expected 0 0", busy8, done8); end
        checks++; if (product8 !== 16'h0000) begin errors++; $display("FAIL abort_product: got %h expected 0000", product8); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        count_done8(15, pulses);
        checks++; if (pulses != 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses expected 0", pulses); end
        issue8(8'd2, 8'd3);
        wait_done8(lat, bc, seen);
        checks++; if (!seen || product8 !== 16'h0006) begin errors++; $display("FAIL abort_restart_product: got %h seen=%b expected 0006", product8, seen); end
        checks++; if (lat != 9) begin errors++; $display("FAIL abort_restart_latency: got %0d expected 9", lat); end
        @(posedge clk); #1;
        $display("test_reset_abort: restart 2*3 product=%h latency=%0d", product8, lat);
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        bit seen;
        issue8(8'h10, 8'h10);
        wait_done8(lat, bc, seen);
        checks++; if (!seen || product8 !== 16'h0100) begin errors++; $display("FAIL b2b_first_product: got %h seen=%b expected 0100", product8, seen); end
        checks++; if (lat != 9) begin errors++; $display("FAIL b2b_first_latency: got %0d expected 9", lat); end
        @(posedge clk); #1;
        issue8(8'h80, 8'h02);
        checks++; if (busy8 !== 1'b1) begin errors++; $display("FAIL b2b_second_accept: got busy=%b expected 1", busy8); end
        wait_done8(lat, bc, seen);
        checks++; if (!seen || product8 !== 16'h0100) begin errors++; $display("FAIL b2b_second_product: got %h seen=%b expected 0100", product8, seen); end
        checks++; if (lat != 9) begin errors++; $display("FAIL b2b_second_latency: got %0d expected 9", lat); end
        @(posedge clk); #1;
        $display("test_back_to_back: second product=%h latency=%0d", product8, lat);
    endtask

    task automatic test_bits4();
        int lat;
        bit seen;
        start4 = 1'b1;
        a4     = 4'hF;
        b4     = 4'hF;
        @(posedge clk); #1;
        start4 = 1'b0;
        lat  = 1;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (done4) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
            lat++;
        end
        checks++; if (!seen || lat != 5) begin errors++; $display("FAIL bits4_latency: got %0d seen=%b expected 5", lat, seen); end
        checks++; if (product4 !== 8'hE1) begin errors++; $display("FAIL bits4_product: got %h expected e1", product4); end
        @(posedge clk); #1;
        $display("test_bits4: 15*15 product=%h latency=%0d", product4, lat);
    endtask

    initial begin
        test_reset();
        test_max();
        test_zero_one();
        test_start_ignored();
        test_reset_abort();
        test_back_to_back();
        test_bits4();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
